// File: rtl/controller_op_stack.sv
// ---------------------------------------------------------------------------
// controller_op_stack
//
// Operator-stack sequencer for the calculator controller. It takes decoded
// keypad commands and keeps a LIFO of pending operators. Precedence and
// parentheses are resolved by issuing reduce requests to the ALU/number-stack
// side over a valid/ready handshake.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   cmd_valid    command offered
//   cmd_ready    command accepted when high together with cmd_valid
//   cmd          0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LP, 5 RP, 6 EQ, 7 CLR
//                (other codes are accepted and ignored)
//   red_valid    reduce request pending
//   red_ready    ALU side consumes the reduce
//   red_op       operator to apply: 0 AD, 1 SB, 2 MU, 3 DI
//   done         one-cycle pulse after an EQ has fully drained
//   err          high while in the error state, until CLR
//   err_code     0 none, 1 overflow, 2 unmatched RP, 3 unmatched LP
//   depth        stack occupancy, 0..DEPTH
//   top_op       operator on top of the stack, 0 when empty (LP reads as 4)
// ---------------------------------------------------------------------------
module controller_op_stack #(
  parameter int CMD_W = 5,
  parameter int OP_W  = 3,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd,
  output logic             red_valid,
  input  logic             red_ready,
  output logic [OP_W-1:0]  red_op,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [PTR_W:0]   depth,
  output logic [OP_W-1:0]  top_op
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN_OP,
    DRAIN_RP,
    DRAIN_EQ,
    ERROR
  } state_t;

  localparam logic [CMD_W-1:0] CMD_LP  = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_RP  = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_EQ  = CMD_W'(6);
  localparam logic [CMD_W-1:0] CMD_CLR = CMD_W'(7);
  localparam logic [OP_W-1:0]  OP_LP   = OP_W'(4);
  localparam logic [PTR_W:0]   FULL_DEPTH = (PTR_W+1)'(DEPTH);

  state_t                          state_q, state_d;
  logic [PTR_W:0]                  depth_q, depth_d;
  logic [DEPTH-1:0][OP_W-1:0]      stack_q, stack_d;
  logic [OP_W-1:0]                 pending_q, pending_d;
  logic [1:0]                      err_code_q, err_code_d;
  logic                            done_q, done_d;

  logic                            empty;
  logic                            full;
  logic [PTR_W-1:0]                top_idx;
  logic [PTR_W-1:0]                wr_idx;
  logic [OP_W-1:0]                 top;
  logic                            accept;
  logic                            cmd_is_op;
  logic [OP_W-1:0]                 cmd_op;

  // Operator codes 2 and 3 (MU/DI) have bit 1 set, so precedence is
  // just that bit: a >= b unless a is additive while b is multiplicative.
  function automatic logic outranks(input logic [OP_W-1:0] a,
                                    input logic [OP_W-1:0] b);
    return a[1] || !b[1];
  endfunction

  // True when the current top may be reduced ahead of operator x.
  function automatic logic top_reducible(input logic             is_empty,
                                         input logic [OP_W-1:0]  cur_top,
                                         input logic [OP_W-1:0]  x);
    return !is_empty && (cur_top != OP_LP) && outranks(cur_top, x);
  endfunction

  assign empty     = (depth_q == '0);
  assign full      = (depth_q == FULL_DEPTH);
  assign top_idx   = PTR_W'(depth_q - 1'b1);
  assign wr_idx    = depth_q[PTR_W-1:0];
  assign top       = empty ? '0 : stack_q[top_idx];
  assign cmd_ready = (state_q == IDLE) || (state_q == ERROR);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_is_op = (cmd < CMD_W'(4));
  assign cmd_op    = cmd[OP_W-1:0];

  assign err      = (state_q == ERROR);
  assign err_code = err_code_q;
  assign done     = done_q;
  assign depth    = depth_q;
  assign top_op   = top;

  // Next-state and output logic. Reduce requests are driven straight from
  // the registered state and top of stack, so they stay stable while the
  // ALU side stalls and only advance on the edge where red_ready is seen.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    stack_d    = stack_q;
    pending_d  = pending_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    red_valid  = 1'b0;
    red_op     = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_is_op) begin
            if (top_reducible(empty, top, cmd_op)) begin
              pending_d = cmd_op;
              state_d   = DRAIN_OP;
            end else if (full) begin
              err_code_d = 2'd1;
              state_d    = ERROR;
            end else begin
              stack_d[wr_idx] = cmd_op;
              depth_d         = depth_q + 1'b1;
            end
          end else if (cmd == CMD_LP) begin
            if (full) begin
              err_code_d = 2'd1;
              state_d    = ERROR;
            end else begin
              stack_d[wr_idx] = OP_LP;
              depth_d         = depth_q + 1'b1;
            end
          end else if (cmd == CMD_RP) begin
            state_d = DRAIN_RP;
          end else if (cmd == CMD_EQ) begin
            state_d = DRAIN_EQ;
          end else if (cmd == CMD_CLR) begin
            depth_d = '0;
          end
        end
      end

      // The final push cannot overflow: entering this state implies at
      // least one pop will happen first.
      DRAIN_OP: begin
        if (top_reducible(empty, top, pending_q)) begin
          red_valid = 1'b1;
          red_op    = top;
          if (red_ready) depth_d = depth_q - 1'b1;
        end else begin
          stack_d[wr_idx] = pending_q;
          depth_d         = depth_q + 1'b1;
          state_d         = IDLE;
        end
      end

      DRAIN_RP: begin
        if (empty) begin
          err_code_d = 2'd2;
          state_d    = ERROR;
        end else if (top == OP_LP) begin
          depth_d = depth_q - 1'b1;
          state_d = IDLE;
        end else begin
          red_valid = 1'b1;
          red_op    = top;
          if (red_ready) depth_d = depth_q - 1'b1;
        end
      end

      DRAIN_EQ: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (top == OP_LP) begin
          err_code_d = 2'd3;
          state_d    = ERROR;
        end else begin
          red_valid = 1'b1;
          red_op    = top;
          if (red_ready) depth_d = depth_q - 1'b1;
        end
      end

      // Everything except CLR is swallowed until the error is cleared.
      ERROR: begin
        if (accept && (cmd == CMD_CLR)) begin
          err_code_d = 2'd0;
          depth_d    = '0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset so a reset mid-drain drops all
  // handshake outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      stack_q    <= '0;
      pending_q  <= '0;
      err_code_q <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      stack_q    <= stack_d;
      pending_q  <= pending_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_controller_op_stack.sv
// ---------------------------------------------------------------------------
// tb_controller_op_stack
//
// Self-checking bench for controller_op_stack: a table of command vectors
// with hand-derived expected results, hand-written sequences for overflow,
// stalled handshakes and asynchronous reset, and a randomized run compared
// against a transaction-level model of the operator stack.
// ---------------------------------------------------------------------------
module tb_controller_op_stack;

  localparam int CMD_W = 5;
  localparam int OP_W  = 3;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  localparam int C_ADD = 0;
  localparam int C_SUB = 1;
  localparam int C_MUL = 2;
  localparam int C_DIV = 3;
  localparam int C_LP  = 4;
  localparam int C_RP  = 5;
  localparam int C_EQ  = 6;
  localparam int C_CLR = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd;
  logic             red_valid;
  logic             red_ready;
  logic [OP_W-1:0]  red_op;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [PTR_W:0]   depth;
  logic [OP_W-1:0]  top_op;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reduces observed by the bench for the current command.
  int got_q[$];
  bit got_done;

  // Reference model: operator stack as a queue, plus expected reduce list.
  int mq[$];
  int m_code;
  int exp_q[$];
  bit exp_done;

  typedef struct {
    int cmd;
    int depth;
    int top;
    int err;
    int code;
    int nred;
    int red0;
    int done;
  } vec_t;

  vec_t vecs[$];

  controller_op_stack #(
    .CMD_W(CMD_W),
    .OP_W (OP_W),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd      (cmd),
    .red_valid(red_valid),
    .red_ready(red_ready),
    .red_op   (red_op),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .depth    (depth),
    .top_op   (top_op)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = '0;
    red_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one command, then service reduce requests (random or always-ready
  // red_ready) until the controller can take commands again. Also checks
  // that a stalled request holds its operator.
  task automatic apply_stimulus(input int c, input bit rand_ready);
    int  cycles;
    bit  hold_prev;
    logic [OP_W-1:0] op_prev;
    got_q.delete();
    got_done  = 1'b0;
    hold_prev = 1'b0;
    op_prev   = '0;
    cycles    = 0;
    @(negedge clk);
    check_output("done_single_cycle", {31'd0, done}, 32'd0);
    check_output("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd       = CMD_W'(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      if (hold_prev) begin
        check_output("stall_valid", {31'd0, red_valid}, 32'd1);
        check_output("stall_op", {29'd0, red_op}, {29'd0, op_prev});
      end
      if (cmd_ready) break;
      red_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (red_valid && red_ready) got_q.push_back(int'(red_op));
      hold_prev = red_valid && !red_ready;
      op_prev   = red_op;
      cycles++;
      if (cycles > 100) begin
        check_output("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
    red_ready = 1'b0;
  endtask

  function automatic int prec(input int op);
    return (op >= 2) ? 2 : 1;
  endfunction

  // Apply one command's effect to the model using the stacking rules
  // directly: reduce while the top outranks, then push or flag an error.
  task automatic model_step(input int c);
    exp_q.delete();
    exp_done = 1'b0;
    if (m_code != 0) begin
      if (c == C_CLR) begin
        mq.delete();
        m_code = 0;
      end
      return;
    end
    if (c <= C_DIV) begin
      while (mq.size() > 0 && mq[$] != C_LP && prec(mq[$]) >= prec(c))
        exp_q.push_back(mq.pop_back());
      if (exp_q.size() == 0 && mq.size() == DEPTH) m_code = 1;
      else mq.push_back(c);
    end else if (c == C_LP) begin
      if (mq.size() == DEPTH) m_code = 1;
      else mq.push_back(C_LP);
    end else if (c == C_RP || c == C_EQ) begin
      while (mq.size() > 0 && mq[$] != C_LP) exp_q.push_back(mq.pop_back());
      if (c == C_RP) begin
        if (mq.size() == 0) m_code = 2;
        else void'(mq.pop_back());
      end else begin
        if (mq.size() == 0) exp_done = 1'b1;
        else m_code = 3;
      end
    end else if (c == C_CLR) begin
      mq.delete();
    end
  endtask

  task automatic compare_model();
    int n;
    check_output("rand_nred", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_output("rand_red_op", got_q[i], exp_q[i]);
    check_output("rand_depth", {28'd0, depth}, mq.size());
    check_output("rand_top", {29'd0, top_op}, (mq.size() > 0) ? mq[$] : 0);
    check_output("rand_err", {31'd0, err}, (m_code != 0) ? 1 : 0);
    check_output("rand_code", {30'd0, err_code}, m_code);
    check_output("rand_done", {31'd0, got_done}, {31'd0, exp_done});
  endtask

  task automatic check_state(input string tag, input int d, input int t,
                             input int e, input int code);
    check_output({tag, "_depth"}, {28'd0, depth}, d);
    check_output({tag, "_top"}, {29'd0, top_op}, t);
    check_output({tag, "_err"}, {31'd0, err}, e);
    check_output({tag, "_code"}, {30'd0, err_code}, code);
  endtask

  initial begin
    int wait_cycles;
    int c;
    int r;

    // cmd, depth, top, err, code, nred, red0, done
    vecs.push_back('{C_ADD, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{C_MUL, 2, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{C_EQ,  0, 0, 0, 0, 2, 2, 1});
    vecs.push_back('{C_MUL, 1, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{C_ADD, 1, 0, 0, 0, 1, 2, 0});
    vecs.push_back('{C_CLR, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{C_LP,  1, 4, 0, 0, 0, 0, 0});
    vecs.push_back('{C_ADD, 2, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{C_RP,  0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{C_SUB, 1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{C_CLR, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{C_RP,  0, 0, 1, 2, 0, 0, 0});
    vecs.push_back('{C_ADD, 0, 0, 1, 2, 0, 0, 0});
    vecs.push_back('{C_CLR, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{C_LP,  1, 4, 0, 0, 0, 0, 0});
    vecs.push_back('{C_EQ,  1, 4, 1, 3, 0, 0, 0});
    vecs.push_back('{C_CLR, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{C_DIV, 1, 3, 0, 0, 0, 0, 0});
    vecs.push_back('{C_MUL, 1, 2, 0, 0, 1, 3, 0});
    vecs.push_back('{9,     1, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{C_ADD, 1, 0, 0, 0, 1, 2, 0});

    do_reset();
    #1;
    check_state("reset", 0, 0, 0, 0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_red_valid", {31'd0, red_valid}, 32'd0);
    check_output("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Table-driven vectors applied in order from reset.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].cmd, 1'b1);
      check_output("vec_nred", got_q.size(), vecs[i].nred);
      if (vecs[i].nred > 0 && got_q.size() > 0)
        check_output("vec_red_op", got_q[0], vecs[i].red0);
      check_state("vec", vecs[i].depth, vecs[i].top, vecs[i].err, vecs[i].code);
      check_output("vec_done", {31'd0, got_done}, vecs[i].done);
    end

    // Overflow: eight LPs fill the stack, the ninth errors out.
    apply_stimulus(C_CLR, 1'b0);
    for (int i = 0; i < DEPTH; i++) apply_stimulus(C_LP, 1'b0);
    check_state("fill", DEPTH, 4, 0, 0);
    apply_stimulus(C_LP, 1'b0);
    check_state("overflow", DEPTH, 4, 1, 1);
    apply_stimulus(C_ADD, 1'b0);
    check_state("overflow_drop", DEPTH, 4, 1, 1);
    apply_stimulus(C_CLR, 1'b0);
    check_state("overflow_clr", 0, 0, 0, 0);

    // Stalled reduce: ADD, ADD with red_ready held low for five cycles.
    apply_stimulus(C_ADD, 1'b0);
    @(negedge clk);
    cmd       = CMD_W'(C_ADD);
    cmd_valid = 1'b1;
    red_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_output("hold_red_valid", {31'd0, red_valid}, 32'd1);
      check_output("hold_red_op", {29'd0, red_op}, 32'd0);
      check_output("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    red_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    red_ready = 1'b0;
    check_output("release_red_valid", {31'd0, red_valid}, 32'd0);
    wait_cycles = 0;
    while (!cmd_ready && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    check_output("release_ready", {31'd0, cmd_ready}, 32'd1);
    check_state("release", 1, 0, 0, 0);

    // Same stall again, then reset asserted between clock edges.
    @(negedge clk);
    cmd       = CMD_W'(C_ADD);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_output("predrain_red_valid", {31'd0, red_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_state("async_reset", 0, 0, 0, 0);
    check_output("async_red_valid", {31'd0, red_valid}, 32'd0);
    check_output("async_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_output("async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized commands against the model.
    do_reset();
    mq.delete();
    m_code = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      c = $urandom_range(C_ADD, C_DIV);
      else if (r < 13) c = C_LP;
      else if (r < 16) c = C_RP;
      else if (r < 18) c = C_EQ;
      else if (r < 19) c = C_CLR;
      else             c = $urandom_range(8, 31);
      if (m_code != 0 && $urandom_range(0, 1) == 1) c = C_CLR;
      model_step(c);
      apply_stimulus(c, 1'b1);
      compare_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/controller_op_stack.md
Name: controller_op_stack

Overview:
- Parametrised operator-stack sequencer for the calculator controller.
- Accepts decoded keypad commands and maintains an operator LIFO of configurable depth.
- Resolves precedence and parentheses by issuing reduce requests to the ALU/number-stack side over a valid/ready handshake.
- Generalises the single operator register into a full precedence-resolving stack with error detection.

Parameters:
- CMD_W, 5, command code width.
- OP_W, 3, operator code width.
- DEPTH, 8, operator stack entries.
- PTR_W, 3, log2(DEPTH).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd  input  CMD_W  command: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LP, 5 RP, 6 EQ, 7 CLR. Other codes are accepted with no effect.
- red_valid  output  1  reduce request pending.
- red_ready  input  1  ALU side consumes the reduce.
- red_op  output  OP_W  operator to apply: 0 AD, 1 SB, 2 MU, 3 DI.
- done  output  1  one-cycle pulse when an EQ fully drains.
- err  output  1  sticky error flag.
- err_code  output  2  error cause: 0 none, 1 overflow, 2 unmatched RP, 3 unmatched LP.
- depth  output  PTR_W+1  stack occupancy, 0..DEPTH.
- top_op  output  OP_W  stack[depth-1]; 0 when empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-drain):
  - state IDLE, depth 0, pending op 0.
  - err 0, err_code 0, done 0, red_valid 0.
  - cmd_ready reflects IDLE (1).
- Precedence: AD/SB = 1, MU/DI = 2. LP on the stack is never reduced by an operator.
- Stack code for LP is 4.
- States: IDLE, DRAIN_OP, DRAIN_RP, DRAIN_EQ, ERROR.
- cmd_ready = 1 in IDLE and ERROR, 0 in every DRAIN state.
- IDLE, on accept:
  - Binary op X:
    - If depth > 0, top != LP and prec(top) >= prec(X): latch X as pending, go to DRAIN_OP.
    - Else push X in the same cycle. If full: no push, err_code 1, go to ERROR.
  - LP: push; if full, err_code 1, go to ERROR.
  - RP: go to DRAIN_RP.
  - EQ: go to DRAIN_EQ.
  - CLR: depth := 0, stay in IDLE.
- DRAIN_OP, evaluated each cycle:
  - If depth > 0, top != LP and prec(top) >= prec(pending): red_valid = 1, red_op = top; on red_ready, pop.
  - Otherwise: red_valid = 0, push pending, return to IDLE. The push cannot overflow because at least one pop preceded it.
- DRAIN_RP:
  - If empty: err_code 2, go to ERROR.
  - Else if top == LP: pop, go to IDLE.
  - Else reduce top as above.
- DRAIN_EQ:
  - If empty: go to IDLE; done is registered high for exactly the next cycle.
  - Else if top == LP: err_code 3, go to ERROR.
  - Else reduce top.
- ERROR:
  - err = 1; all commands are accepted and dropped, except CLR.
  - CLR clears err, err_code and the stack, and returns to IDLE.
- Handshake:
  - Once red_valid rises, red_valid and red_op hold stable until red_ready is sampled high.
  - The pop occurs on that edge.
  - red_valid may fall the cycle after the pop if the next top does not qualify.
- Simultaneous events: cmd_valid is ignored while cmd_ready = 0. No command is lost, because the source must hold cmd_valid.
- Throughput: an op that needs no reduce is pushed in its accept cycle, and the next command can be accepted the following cycle.

Test Plan:
1. Reset; ADD, MUL, EQ with red_ready = 1 → red_op MU, then AD. done pulses 1 cycle. depth 0, err 0.
2. MUL, then ADD → exactly one reduce with red_op = 2, then depth = 1 and top_op = 0 (AD); cmd_ready returns to 1.
3. LP, ADD, RP → one reduce with red_op = 0, then LP popped, depth 0, no error. Follow with SUB: depth 1, top_op = 1.
4. DEPTH = 8: nine LPs → the first eight push (depth 8); the ninth sets err = 1, err_code 1 with depth held at 8. A following ADD is dropped. CLR → depth 0, err 0.
5. RP on empty → err_code 2. After CLR: LP, EQ → err_code 3, no reduce issued.
6. ADD, ADD with red_ready held low 5 cycles:
   - red_valid stays 1, red_op stays 0, cmd_ready stays 0 throughout.
   - Release → pop, then push, depth 1.
   - Repeat and assert Reset mid-drain → all outputs at reset values immediately, without waiting for a clock edge.
